muldiv_hilo_unit: RTL and testbench

Multi-cycle multiply/divide sequencer with architectural HI/LO registers, sitting beside the single-cycle ALU in the execute stage. It executes mult/multu/div/divu one bit per cycle and services mthi/mtlo writes. HI/LO contents are exposed continuously for mfhi/mflo. The pipeline controller uses `busy` to stall any instruction that reads HI/LO or issues a new mult/div.

---
 rtl/muldiv_hilo_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_hilo_unit
// Purpose  : Bit-serial mult/multu/div/divu sequencer with architectural
//            HI/LO registers and mthi/mtlo write port.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             abort,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              c_CW    = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_ITERS = c_CW'(WIDTH);
    localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);
    localparam logic [0:0]      c_IDLE  = 1'b0;
    localparam logic [0:0]      c_RUN   = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [c_CW-1:0]    r_count;
    logic               r_op;
    logic               r_dbz;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_done;
    logic [WIDTH-1:0]   r_mag_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_accept;
    logic               w_last;
    logic               w_neg_a;
    logic               w_neg_b;
    logic               w_dbz;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_rem;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_accept = (r_state == c_IDLE) && start && !abort;
    assign w_last   = (r_state == c_RUN) && !abort && (r_count == c_ONE);
    assign w_neg_a  = sgn & src_a[WIDTH-1];
    assign w_neg_b  = sgn & src_b[WIDTH-1];
    assign w_dbz    = op && (src_b == '0);
    assign w_mag_a  = w_neg_a ? -src_a : src_a;

    // Multiply: accumulator is {partial product, remaining multiplier bits}.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_mag_b : '0)};

    // Divide: accumulator is {partial remainder, remaining dividend / quotient bits}.
    assign w_div_rem  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff = w_div_rem - {1'b0, r_mag_b};
    assign w_div_ok   = !w_div_diff[WIDTH];

    always_comb begin
        w_acc_step = r_acc;
        if (r_op) begin
            w_acc_step = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_rem[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ok};
        end else begin
            w_acc_step = {w_mul_sum, r_acc[WIDTH-1:1]};
        end
    end

    assign w_prod = r_neg_q ? -w_acc_step : w_acc_step;
    assign w_quo  = r_neg_q ? -w_acc_step[WIDTH-1:0] : w_acc_step[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -w_acc_step[2*WIDTH-1:WIDTH] : w_acc_step[2*WIDTH-1:WIDTH];

    // Divide by zero returns the original dividend, rebuilt from its magnitude.
    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_dbz) begin
            w_res_hi = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            w_res_lo = '1;
        end else if (r_op) begin
            w_res_hi = w_rem;
            w_res_lo = w_quo;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_next = c_RUN;
            c_RUN:   if (abort || (r_count == c_ONE)) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_count <= '0;
            r_op    <= 1'b0;
            r_dbz   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_done  <= 1'b0;
            r_mag_b <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_last;
            if (w_accept) begin
                r_op    <= op;
                r_dbz   <= w_dbz;
                r_neg_q <= w_neg_a ^ w_neg_b;
                r_neg_r <= w_neg_a;
                r_mag_b <= w_neg_b ? -src_b : src_b;
                r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
                r_count <= w_dbz ? c_ONE : c_ITERS;
            end else if (r_state == c_RUN) begin
                r_acc   <= w_acc_step;
                r_count <= abort ? '0 : (r_count - c_ONE);
            end
            // The completing result wins over any concurrent mthi/mtlo.
            if (w_last) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (r_state == c_IDLE) begin
                if (wr_hi) r_hi <= wr_data;
                if (wr_lo) r_lo <= wr_data;
            end
        end
    end

    assign busy = (r_state == c_RUN);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_hilo_unit
// Purpose  : Scoreboard bench for muldiv_hilo_unit with a 64-bit arithmetic
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_hilo_unit;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              op = 1'b0;
    logic              sgn = 1'b0;
    logic              abort = 1'b0;
    logic              wr_hi = 1'b0;
    logic              wr_lo = 1'b0;
    logic [WIDTH-1:0]  src_a = '0;
    logic [WIDTH-1:0]  src_b = '0;
    logic [WIDTH-1:0]  wr_data = '0;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int run = 0;
    logic [WIDTH-1:0] m_hi = '0;
    logic [WIDTH-1:0] m_lo = '0;

    typedef struct {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        int               cyc;
        int               blen;
    } exp_t;
    exp_t scb[$];

    muldiv_hilo_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sgn(sgn),
        .src_a(src_a), .src_b(src_b), .abort(abort), .wr_hi(wr_hi),
        .wr_lo(wr_lo), .wr_data(wr_data), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic o, input logic s,
                                               input logic [31:0] a, input logic [31:0] b);
        longint sa, sbv;
        logic [63:0] p;
        logic [31:0] q, r;
        sa  = s ? longint'($signed(a)) : longint'({32'b0, a});
        sbv = s ? longint'($signed(b)) : longint'({32'b0, b});
        if (!o) begin
            p = sa * sbv;
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = 32'(sa / sbv);
        r = 32'(sa % sbv);
        return {r, q};
    endfunction

    task automatic issue(input logic o, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input bit push);
        logic [63:0] r;
        int lat;
        @(negedge clk);
        start = 1'b1; op = o; sgn = s; src_a = a; src_b = b;
        if (push) begin
            r   = ref_result(o, s, a, b);
            lat = (o && b == 32'd0) ? 1 : WIDTH;
            scb.push_back(exp_t'{r[63:32], r[31:0], cyc + 1 + lat, lat});
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < WIDTH + 8 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: done not seen within %0d cycles", name, WIDTH + 8);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals completion.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst_n && done) begin
                exp_t e;
                if (scb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 required done=0");
                end else begin
                    e = scb.pop_front();
                    check("result_hi", hi, e.hi);
                    check("result_lo", lo, e.lo);
                    check("done_cycle", cyc, e.cyc);
                    check("busy_cycles", run, e.blen);
                    check("busy_in_done", {31'b0, busy}, 32'd0);
                end
            end
            if (rst_n && busy) run++;
            else run = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] hold_hi;
        logic             o, s;
        logic [WIDTH-1:0] a, b;

        repeat (3) @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;

        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_done("multu_max");
        issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1);         wait_done("div_neg7_2");
        issue(1'b1, 1'b0, 32'd7, 32'd2, 1);                 wait_done("divu_7_2");
        issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done("div_minneg");
        issue(1'b1, 1'b0, 32'h1234_5678, 32'd0, 1);         wait_done("divu_by_zero");

        // mtlo in the accepting cycle, then mthi during RUN
        hold_hi = m_hi;
        @(negedge clk);
        start = 1'b1; op = 1'b0; sgn = 1'b0; src_a = 32'd3; src_b = 32'd5;
        wr_lo = 1'b1; wr_data = 32'hA5A5_A5A5;
        scb.push_back(exp_t'{32'd0, 32'd15, cyc + 1 + WIDTH, WIDTH});
        @(posedge clk); #1;
        check("mtlo_at_start", lo, 32'hA5A5_A5A5);
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        repeat (2) @(negedge clk);
        wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("mthi_in_run_ignored", hi, hold_hi);
        @(negedge clk);
        wr_hi = 1'b0;
        m_hi = 32'd0; m_lo = 32'd15;
        wait_done("mult_3_5_mtlo");

        // abort at RUN cycle 10
        issue(1'b0, 1'b0, 32'd3, 32'd5, 0);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi, m_hi);
        check("abort_lo", lo, m_lo);
        @(negedge clk);
        abort = 1'b0;
        repeat (WIDTH + 4) @(posedge clk);

        // start mid-RUN must be ignored
        issue(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd1000, 1);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 1'b1; src_a = 32'd99; src_b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        wait_done("start_mid_run");

        // back-to-back: next start lands in the done cycle
        issue(1'b1, 1'b1, 32'd100, 32'hFFFF_FFF9, 1); wait_done("b2b_first");
        issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1);   wait_done("b2b_second");

        // asynchronous reset mid-RUN
        issue(1'b0, 1'b0, 32'd123, 32'd456, 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_hi", hi, 32'd0);
        check("areset_lo", lo, 32'd0);
        check("areset_busy", {31'b0, busy}, 32'd0);
        check("areset_done", {31'b0, done}, 32'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 40; n++) begin
            o = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                wr_hi = 1'b1; wr_data = $urandom;
                m_hi = wr_data;
                @(posedge clk); #1;
                check("mthi_idle", hi, m_hi);
                @(negedge clk);
                wr_hi = 1'b0;
            end
            issue(o, s, a, b, 1);
            wait_done("random_op");
        end

        repeat (4) @(posedge clk);
        if (scb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", scb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
